// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath /
// shared single-port memory. The controller side is "master", the datapath
// and memory side is "slave".
interface multicycle_ctrl_if #(
   parameter int CNT_W = 32
);
   // datapath / memory status into the controller
   logic [31:0]      instr;
   logic             zero;
   logic             mem_ready;

   // memory handshake
   logic             mem_req;
   logic             mem_we;

   // datapath controls
   logic             ir_we;
   logic             we;
   logic             rs2sel;
   logic [1:0]       regsel;
   logic [1:0]       imm_sel;
   logic             PCsel;
   logic             pc_we;
   logic [3:0]       ALUControl;

   // status
   logic             trap;
   logic [CNT_W-1:0] instret;

   modport master (
      input  instr, zero, mem_ready,
      output mem_req, mem_we, ir_we, we, rs2sel, regsel, imm_sel,
             PCsel, pc_we, ALUControl, trap, instret
   );

   modport slave (
      output instr, zero, mem_ready,
      input  mem_req, mem_we, ir_we, we, rs2sel, regsel, imm_sel,
             PCsel, pc_we, ALUControl, trap, instret
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM. Sequences fetch, decode, execute, memory
// and write-back over a shared single-port memory, decodes the ALU operation,
// flags illegal encodings and counts retired instructions.
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   multicycle_ctrl_if.master      bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXECUTE,
      MEMORY,
      WRITEBACK
   } state_t;

   typedef enum logic [2:0] {
      C_R,
      C_I,
      C_LW,
      C_SW,
      C_BR,
      C_JAL,
      C_ILL
   } class_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   state_t           state_reg;
   state_t           state_next;
   class_t           cls;
   logic [CNT_W-1:0] instret_reg;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             alt;
   logic [3:0]       alu_op;

   logic             mem_req;
   logic             mem_we;
   logic             ir_we;
   logic             we;
   logic             rs2sel;
   logic [1:0]       regsel;
   logic [1:0]       imm_sel;
   logic             PCsel;
   logic             pc_we;
   logic [3:0]       ALUControl;
   logic             trap;

   // Register specifiers and immediate bits are consumed by the datapath only.
   logic             unused_instr_bits;

   assign opcode = bus.instr[6:0];
   assign funct3 = bus.instr[14:12];
   assign alt    = bus.instr[30];
   assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

   // ALU operation for register and immediate arithmetic; funct3 000 is only
   // a subtract for the register form.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                             input logic       f_alt,
                                             input logic       is_reg);
      logic [3:0] op;
      case (f3)
         3'b000:  op = (is_reg && f_alt) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f_alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   assign alu_op = alu_decode(funct3, alt, (cls == C_R));

   // Instruction class from the IR; anything not recognised is illegal.
   always_comb begin
      cls = C_ILL;
      case (opcode)
         OP_R:   cls = C_R;
         OP_I:   cls = C_I;
         OP_LW:  if (funct3 == 3'b010) cls = C_LW;
         OP_SW:  if (funct3 == 3'b010) cls = C_SW;
         OP_BR:  if (funct3[2:1] == 2'b00) cls = C_BR;
         OP_JAL: cls = C_JAL;
         default: cls = C_ILL;
      endcase
   end

   // State register; reset abandons any in-flight memory request.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and all datapath controls, decoded from state, class and mem_ready.
   always_comb begin
      state_next = state_reg;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_we      = 1'b0;
      we         = 1'b0;
      rs2sel     = 1'b0;
      regsel     = WB_ALU;
      imm_sel    = IMM_I;
      PCsel      = 1'b0;
      pc_we      = 1'b0;
      ALUControl = ALU_ADD;
      trap       = 1'b0;

      case (state_reg)
         IDLE: begin
            state_next = FETCH;
         end

         FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_we      = 1'b1;
               state_next = DECODE;
            end
         end

         DECODE: begin
            if (cls == C_ILL) begin
               trap       = 1'b1;
               pc_we      = 1'b1;
               state_next = FETCH;
            end else if (cls == C_JAL) begin
               state_next = WRITEBACK;
            end else begin
               state_next = EXECUTE;
            end
         end

         EXECUTE: begin
            case (cls)
               C_R: begin
                  ALUControl = alu_op;
                  state_next = WRITEBACK;
               end
               C_I: begin
                  rs2sel     = 1'b1;
                  ALUControl = alu_op;
                  state_next = WRITEBACK;
               end
               C_LW, C_SW: begin
                  rs2sel     = 1'b1;
                  imm_sel    = (cls == C_SW) ? IMM_S : IMM_I;
                  state_next = MEMORY;
               end
               C_BR: begin
                  ALUControl = ALU_SUB;
                  imm_sel    = IMM_B;
                  pc_we      = 1'b1;
                  // funct3[0] distinguishes BNE from BEQ
                  PCsel      = funct3[0] ? ~bus.zero : bus.zero;
                  state_next = FETCH;
               end
               default: state_next = FETCH;
            endcase
         end

         MEMORY: begin
            mem_req = 1'b1;
            mem_we  = (cls == C_SW);
            rs2sel  = 1'b1;
            imm_sel = (cls == C_SW) ? IMM_S : IMM_I;
            if (bus.mem_ready) begin
               if (cls == C_SW) begin
                  pc_we      = 1'b1;
                  state_next = FETCH;
               end else begin
                  state_next = WRITEBACK;
               end
            end
         end

         WRITEBACK: begin
            we         = 1'b1;
            pc_we      = 1'b1;
            state_next = FETCH;
            case (cls)
               C_R: begin
                  ALUControl = alu_op;
               end
               C_I: begin
                  rs2sel     = 1'b1;
                  ALUControl = alu_op;
               end
               C_LW: begin
                  regsel = WB_MEM;
               end
               C_JAL: begin
                  regsel  = WB_PC4;
                  imm_sel = IMM_J;
                  PCsel   = 1'b1;
               end
               default: ;
            endcase
         end

         default: state_next = IDLE;
      endcase
   end

   // Retired-instruction counter: every PC update except a trap retires one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         instret_reg <= '0;
      end else if (pc_we && !trap) begin
         instret_reg <= instret_reg + 1'b1;
      end
   end

   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we;
   assign bus.ir_we      = ir_we;
   assign bus.we         = we;
   assign bus.rs2sel     = rs2sel;
   assign bus.regsel     = regsel;
   assign bus.imm_sel    = imm_sel;
   assign bus.PCsel      = PCsel;
   assign bus.pc_we      = pc_we;
   assign bus.ALUControl = ALUControl;
   assign bus.trap       = trap;
   assign bus.instret    = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus pushes expected memory
// handshakes and retire records; a monitor compares them when the DUT
// completes a memory request or updates the PC.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       mem_we;
      logic       ir_we;
      logic [1:0] imm;
   } mem_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  regsel;
      logic        pcsel;
      logic        trap;
      logic [3:0]  alu;
      logic        rs2;
      logic [1:0]  imm;
      logic [7:0]  lat;
      logic [31:0] cnt;
   } ret_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instr = '0;
   logic        zero = 1'b0;
   logic        ready = 1'b0;
   logic        force_ready = 1'b1;
   logic        rst_q = 1'b0;
   logic        done = 1'b0;
   logic        done_seen = 1'b0;
   logic        in_rst = 1'b0;
   logic [31:0] exp_cnt = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stall = 0;
   int stray = 0;
   int waited = 0;
   int nret = 0;

   mem_t mem_q[$];
   ret_t ret_q[$];
   int   wait_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl_if #(.CNT_W(32)) bus ();

   multicycle_ctrl #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.instr     = instr;
   assign bus.zero      = zero;
   assign bus.mem_ready = ready;

   // reset value the DUT saw at the last edge
   always @(posedge clk) rst_q <= reset;

   // memory responder: each request waits the queued number of cycles
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         wait_q.delete();
         waited = 0;
         ready = force_ready;
      end else if (bus.mem_req && wait_q.size() > 0) begin
         if (waited >= wait_q[0]) begin
            ready = 1'b1;
            waited = 0;
            void'(wait_q.pop_front());
         end else begin
            ready = 1'b0;
            waited++;
         end
      end else begin
         ready = 1'b0;
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      mem_t ma;
      mem_t me;
      ret_t ra;
      ret_t re;
      if (!rst_q) begin
         checks++;
         if ({bus.mem_req, bus.mem_we, bus.ir_we, bus.we, bus.rs2sel, bus.regsel,
              bus.imm_sel, bus.PCsel, bus.pc_we, bus.ALUControl, bus.trap} !== '0 ||
             bus.instret !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: mem_req=%b we=%b pc_we=%b ir_we=%b trap=%b instret=%0d, required all 0",
                     bus.mem_req, bus.we, bus.pc_we, bus.ir_we, bus.trap, bus.instret);
         end
         mem_q.delete();
         ret_q.delete();
         in_rst = 1'b1;
         stall = 0;
         stray = 0;
      end else begin
         if (in_rst) begin
            checks++;
            if (bus.mem_req !== 1'b1) begin
               errors++;
               $display("FAIL first_fetch: mem_req=%b, required 1 one cycle after reset release", bus.mem_req);
            end
         end
         in_rst = 1'b0;
         cyc++;
         if (bus.ir_we) cyc = 1;
         if (bus.we && !bus.pc_we) stray++;

         if (bus.mem_req && bus.mem_ready) begin
            checks++;
            if (mem_q.size() == 0) begin
               errors++;
               $display("FAIL mem_done: unexpected completed request mem_we=%b", bus.mem_we);
            end else begin
               me = mem_q.pop_front();
               ma = '{mem_we: bus.mem_we, ir_we: bus.ir_we, imm: bus.imm_sel};
               if (ma !== me) begin
                  errors++;
                  $display("FAIL mem_done: mem_we=%b ir_we=%b imm_sel=%b, required mem_we=%b ir_we=%b imm_sel=%b",
                           ma.mem_we, ma.ir_we, ma.imm, me.mem_we, me.ir_we, me.imm);
               end
            end
         end else if (bus.mem_req && mem_q.size() > 0) begin
            checks++;
            if ({bus.mem_we, bus.ir_we, bus.we, bus.pc_we, bus.imm_sel} !==
                {mem_q[0].mem_we, 3'b000, mem_q[0].imm}) begin
               errors++;
               $display("FAIL mem_wait: mem_we=%b ir_we=%b we=%b pc_we=%b imm_sel=%b, required mem_we=%b imm_sel=%b and no enables",
                        bus.mem_we, bus.ir_we, bus.we, bus.pc_we, bus.imm_sel, mem_q[0].mem_we, mem_q[0].imm);
            end
         end

         if (bus.pc_we) begin
            checks++;
            if (ret_q.size() == 0) begin
               errors++;
               $display("FAIL retire: unexpected pc_we (trap=%b)", bus.trap);
            end else begin
               re = ret_q.pop_front();
               ra = '{we: bus.we, regsel: bus.regsel, pcsel: bus.PCsel, trap: bus.trap,
                      alu: bus.ALUControl, rs2: bus.rs2sel, imm: bus.imm_sel,
                      lat: 8'(cyc), cnt: bus.instret};
               if (ra !== re) begin
                  errors++;
                  $display("FAIL retire[%0d]: we=%b regsel=%b PCsel=%b trap=%b alu=%b rs2sel=%b imm_sel=%b lat=%0d instret=%0d, required we=%b regsel=%b PCsel=%b trap=%b alu=%b rs2sel=%b imm_sel=%b lat=%0d instret=%0d",
                           nret, ra.we, ra.regsel, ra.pcsel, ra.trap, ra.alu, ra.rs2, ra.imm, ra.lat, ra.cnt,
                           re.we, re.regsel, re.pcsel, re.trap, re.alu, re.rs2, re.imm, re.lat, re.cnt);
               end
            end
            checks++;
            if (stray != 0) begin
               errors++;
               $display("FAIL stray_we[%0d]: %0d we pulses outside pc_we, required 0", nret, stray);
            end
            $display("retire %0d: trap=%b we=%b regsel=%b PCsel=%b alu=%b lat=%0d instret=%0d",
                     nret, bus.trap, bus.we, bus.regsel, bus.PCsel, bus.ALUControl, cyc, bus.instret);
            nret++;
            stray = 0;
            stall = 0;
         end else if (ret_q.size() > 0) begin
            stall++;
            if (stall == 80) begin
               checks++;
               errors++;
               $display("FAIL timeout: no pc_we within 80 cycles, %0d retires pending", ret_q.size());
               ret_q.delete();
               mem_q.delete();
               stall = 0;
            end
         end

         if (done && !done_seen) begin
            done_seen = 1'b1;
            checks++;
            if (ret_q.size() != 0 || mem_q.size() != 0) begin
               errors++;
               $display("FAIL drain: %0d retires and %0d memory events outstanding, required 0",
                        ret_q.size(), mem_q.size());
            end
         end
      end
   end

   // Queue the expectations for one instruction, then step it through the DUT.
   // dkind: 0 no data access, 1 load, 2 store.
   task automatic do_instr(input logic [31:0] ins, input logic z, input int fw,
                           input int dkind, input int dw,
                           input logic e_we, input logic [1:0] e_regsel,
                           input logic e_pcsel, input logic e_trap,
                           input logic [3:0] e_alu, input logic e_rs2,
                           input logic [1:0] e_imm, input int e_lat);
      ret_t r;
      int n;
      wait_q.push_back(fw);
      mem_q.push_back('{mem_we: 1'b0, ir_we: 1'b1, imm: 2'b00});
      if (dkind != 0) begin
         wait_q.push_back(dw);
         mem_q.push_back('{mem_we: (dkind == 2), ir_we: 1'b0, imm: (dkind == 2) ? 2'b01 : 2'b00});
      end
      r = '{we: e_we, regsel: e_regsel, pcsel: e_pcsel, trap: e_trap, alu: e_alu,
            rs2: e_rs2, imm: e_imm, lat: 8'(e_lat), cnt: exp_cnt};
      ret_q.push_back(r);
      if (!e_trap) exp_cnt = exp_cnt + 1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.ir_we && n < 100);
      instr = ins;
      zero = z;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.pc_we && n < 100);
   endtask

   initial begin
      int n;
      // reset held 3 cycles with mem_ready forced high
      reset = 1'b0;
      force_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      force_ready = 1'b0;
      @(negedge clk);

      //        instr         z  fw dk dw we regsel PC tr alu     rs2 imm   lat
      do_instr(32'h002081B3, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'b0000, 0, 2'b00, 4); // ADD
      do_instr(32'h402081B3, 0, 2, 0, 0, 1, 2'b00, 0, 0, 4'b0001, 0, 2'b00, 4); // SUB, fetch wait
      do_instr(32'h0020B1B3, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'b1001, 0, 2'b00, 4); // SLTU
      do_instr(32'hFFF00093, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'b0000, 1, 2'b00, 4); // ADDI -1 (bit30 set)
      do_instr(32'h4030D293, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'b0111, 1, 2'b00, 4); // SRAI
      do_instr(32'h0080A283, 0, 0, 1, 2, 1, 2'b01, 0, 0, 4'b0000, 0, 2'b00, 7); // LW, 2 waits
      do_instr(32'h0020A223, 0, 0, 2, 1, 0, 2'b00, 0, 0, 4'b0000, 1, 2'b01, 5); // SW, 1 wait
      do_instr(32'h00208463, 1, 0, 0, 0, 0, 2'b00, 1, 0, 4'b0001, 0, 2'b10, 3); // BEQ taken
      do_instr(32'h00208463, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0001, 0, 2'b10, 3); // BEQ not taken
      do_instr(32'h00209463, 1, 0, 0, 0, 0, 2'b00, 0, 0, 4'b0001, 0, 2'b10, 3); // BNE not taken
      do_instr(32'h00209463, 0, 0, 0, 0, 0, 2'b00, 1, 0, 4'b0001, 0, 2'b10, 3); // BNE taken
      do_instr(32'h0000007F, 0, 0, 0, 0, 0, 2'b00, 0, 1, 4'b0000, 0, 2'b00, 2); // illegal opcode
      do_instr(32'h010000EF, 0, 0, 0, 0, 1, 2'b10, 1, 0, 4'b0000, 0, 2'b11, 3); // JAL
      do_instr(32'h00008283, 0, 0, 0, 0, 0, 2'b00, 0, 1, 4'b0000, 0, 2'b00, 2); // LB: illegal funct3
      do_instr(32'h002081B3, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'b0000, 0, 2'b00, 4); // ADD after traps

      // LW abandoned by reset while waiting in MEMORY
      wait_q.push_back(0);
      wait_q.push_back(30);
      mem_q.push_back('{mem_we: 1'b0, ir_we: 1'b1, imm: 2'b00});
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.ir_we && n < 100);
      instr = 32'h0080A283;
      repeat (3) @(negedge clk);
      $display("mid-reset: asserting reset with mem_req=%b mem_ready=%b", bus.mem_req, bus.mem_ready);
      reset = 1'b0;
      exp_cnt = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_instr(32'h002081B3, 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'b0000, 0, 2'b00, 4); // ADD after reset

      done = 1'b1;
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
